// File: rtl/decode_stage.sv
// decode_stage: single-stage RV32I/RV64I instruction decoder with a
// valid/ready registered output and an accepted-instruction counter.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN. When it is defined,
// undecodable words raise out_illegal. When it is undefined, out_illegal
// is tied to 0 and such words decode as a NOP.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_aluop,
  output logic             out_regwrite,
  output logic             out_memtoreg,
  output logic             out_memwrite,
  output logic             out_opa,
  output logic             out_opb,
  output logic             out_branch,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Strobe bundle bit order: {regwrite, memtoreg, memwrite, opa, opb, branch, jal, jalr}
  localparam logic [7:0] STRB_R     = 8'b1000_0000;
  localparam logic [7:0] STRB_IALU  = 8'b1001_0000;
  localparam logic [7:0] STRB_LOAD  = 8'b1101_0000;
  localparam logic [7:0] STRB_STORE = 8'b0011_0000;
  localparam logic [7:0] STRB_BR    = 8'b0000_0100;
  localparam logic [7:0] STRB_JAL   = 8'b1000_0010;
  localparam logic [7:0] STRB_JALR  = 8'b1001_0001;
  localparam logic [7:0] STRB_LUI   = 8'b1001_0000;
  localparam logic [7:0] STRB_AUIPC = 8'b1001_1000;

  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic             alt_s;
  logic [5:0]       aluop_raw_s;
  logic [7:0]       strb_raw_s;
  logic             bad_s;
  logic [5:0]       aluop_d;
  logic [7:0]       strb_d;
  logic [31:0]      imm32_s;
  logic [XLEN-1:0]  imm_d;
  logic             accept_s;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;

  logic             valid_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  imm_q;
  logic [5:0]       aluop_q;
  logic [7:0]       strb_q;
  logic [CNT_W-1:0] count_q;

  assign opcode_s = in_instr[6:0];
  assign funct3_s = in_instr[14:12];
  assign alt_s    = in_instr[30];

  // Classify the opcode/funct3 into an aluop, a strobe set and an undecodable flag.
  always_comb begin
    aluop_raw_s = 6'd0;
    strb_raw_s  = 8'h00;
    bad_s       = 1'b0;
    case (opcode_s)
      OP_LOAD: begin
        strb_raw_s = STRB_LOAD;
        case (funct3_s)
          3'd0:    aluop_raw_s = 6'd0;
          3'd1:    aluop_raw_s = 6'd1;
          3'd2:    aluop_raw_s = 6'd2;
          3'd3: begin
            aluop_raw_s = 6'd3;
            bad_s       = (XLEN == 32);
          end
          3'd4:    aluop_raw_s = 6'd4;
          3'd5:    aluop_raw_s = 6'd14;
          default: bad_s = 1'b1;
        endcase
      end
      OP_OPIMM: begin
        strb_raw_s = STRB_IALU;
        case (funct3_s)
          3'd0:    aluop_raw_s = 6'd5;
          3'd1:    aluop_raw_s = 6'd6;
          3'd2:    aluop_raw_s = 6'd7;
          3'd3:    aluop_raw_s = 6'd8;
          3'd4:    aluop_raw_s = 6'd9;
          3'd5:    aluop_raw_s = alt_s ? 6'd11 : 6'd10;
          3'd6:    aluop_raw_s = 6'd12;
          default: aluop_raw_s = 6'd13;
        endcase
      end
      OP_STORE: begin
        strb_raw_s = STRB_STORE;
        case (funct3_s)
          3'd0:    aluop_raw_s = 6'd15;
          3'd1:    aluop_raw_s = 6'd16;
          3'd2:    aluop_raw_s = 6'd17;
          3'd3: begin
            aluop_raw_s = 6'd28;
            bad_s       = (XLEN == 32);
          end
          default: bad_s = 1'b1;
        endcase
      end
      OP_OP: begin
        strb_raw_s = STRB_R;
        case (funct3_s)
          3'd0:    aluop_raw_s = alt_s ? 6'd19 : 6'd18;
          3'd1:    aluop_raw_s = 6'd20;
          3'd2:    aluop_raw_s = 6'd21;
          3'd3:    aluop_raw_s = 6'd22;
          3'd4:    aluop_raw_s = 6'd23;
          3'd5:    aluop_raw_s = alt_s ? 6'd25 : 6'd24;
          3'd6:    aluop_raw_s = 6'd26;
          default: aluop_raw_s = 6'd27;
        endcase
      end
      OP_BRANCH: begin
        strb_raw_s = STRB_BR;
        case (funct3_s)
          3'd0:    aluop_raw_s = 6'd29;
          3'd1:    aluop_raw_s = 6'd30;
          3'd4:    aluop_raw_s = 6'd31;
          3'd5:    aluop_raw_s = 6'd32;
          3'd6:    aluop_raw_s = 6'd33;
          3'd7:    aluop_raw_s = 6'd34;
          default: bad_s = 1'b1;
        endcase
      end
      OP_JALR: begin
        strb_raw_s  = STRB_JALR;
        aluop_raw_s = 6'd35;
      end
      OP_LUI: begin
        strb_raw_s  = STRB_LUI;
        aluop_raw_s = 6'd36;
      end
      OP_AUIPC: begin
        strb_raw_s  = STRB_AUIPC;
        aluop_raw_s = 6'd37;
      end
      OP_JAL: begin
        strb_raw_s  = STRB_JAL;
        aluop_raw_s = 6'd38;
      end
      default: bad_s = 1'b1;
    endcase
  end

  // Undecodable words carry no operation: strobes and aluop collapse to zero.
  always_comb begin
    if (bad_s) begin
      aluop_d = 6'd0;
      strb_d  = 8'h00;
    end else begin
      aluop_d = aluop_raw_s;
      strb_d  = strb_raw_s;
    end
  end

  // Assemble the 32-bit immediate for the opcode's format; it is widened to XLEN below.
  always_comb begin
    case (opcode_s)
      OP_LOAD, OP_OPIMM, OP_JALR:
        imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
      OP_STORE:
        imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH:
        imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      OP_JAL:
        imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32_s = {in_instr[31:12], 12'h000};
      default:
        imm32_s = 32'h0000_0000;
    endcase
  end

  // Sign cast keeps bit 31 replicated when XLEN is 64.
  assign imm_d = XLEN'($signed(imm32_s));

  // The output stage can take a new word when empty or when its word leaves this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Next valid and count: flush wins, then acceptance, then a plain drain.
  always_comb begin
    if (flush) begin
      valid_d = 1'b0;
      count_d = count_q;
    end else if (accept_s) begin
      valid_d = 1'b1;
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      count_d = count_q;
    end else begin
      valid_d = valid_q;
      count_d = count_q;
    end
  end

  // Output stage and counter; payload loads only on acceptance so a stalled word holds still.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      imm_q   <= {XLEN{1'b0}};
      aluop_q <= 6'd0;
      strb_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (accept_s) begin
        rs1_q   <= in_instr[19:15];
        rs2_q   <= in_instr[24:20];
        rd_q    <= in_instr[11:7];
        imm_q   <= imm_d;
        aluop_q <= aluop_d;
        strb_q  <= strb_d;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Illegal flag travels with its instruction through the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (accept_s) begin
      illegal_q <= bad_s;
    end
  end

  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid    = valid_q;
  assign dec_count    = count_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_imm      = imm_q;
  assign out_aluop    = aluop_q;
  assign out_regwrite = strb_q[7];
  assign out_memtoreg = strb_q[6];
  assign out_memwrite = strb_q[5];
  assign out_opa      = strb_q[4];
  assign out_opb      = strb_q[3];
  assign out_branch   = strb_q[2];
  assign out_jal      = strb_q[1];
  assign out_jalr     = strb_q[0];

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the decoded-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_instr is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage accepts in_instr this cycle.
REQ-007 SHALL have port in_instr, input, 32 bits: RV32I/RV64I instruction word.
REQ-008 SHALL have port flush, input, 1 bit: discard the held and incoming instruction.
REQ-009 SHALL have port out_valid, input ... corrected: out_valid, output, 1 bit: registered decode is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the output this cycle.
REQ-011 SHALL have ports out_rs1, out_rs2 and out_rd, each an output of 5 bits: register indices, instr[19:15], [24:20] and [11:7].
REQ-012 SHALL have port out_imm, output, XLEN bits: sign-extended immediate.
REQ-013 SHALL have port out_aluop, output, 6 bits: operation code.
REQ-014 SHALL have ports out_regwrite, out_memtoreg, out_memwrite, out_opa, out_opb, out_branch, out_jal and out_jalr, each an output of 1 bit: control strobes.
REQ-015 SHALL have port out_illegal, output, 1 bit: the instruction is not decodable.
REQ-016 SHALL have port dec_count, output, CNT_W bits: number of instructions accepted since reset.

Function
REQ-017 SHALL register the decode in a single output stage: an instruction accepted in cycle N appears on out_* in cycle N+1 (latency 1).
REQ-018 SHALL drive in_ready = !out_valid || out_ready, so that full throughput is one instruction per cycle when out_ready is held high.
REQ-019 SHALL define acceptance as in_valid && in_ready && !flush; on acceptance, out_* and out_valid=1 are loaded.
REQ-020 SHALL clear out_valid when out_valid && out_ready and there is no acceptance.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, clear out_valid on the next edge, accept no instruction, and leave dec_count unchanged; flush dominates every other event in the same cycle.
REQ-023 SHALL decode immediates by opcode as follows, all sign-extended from bit 31 to XLEN:
 - I-format for opcodes 0000011, 0010011 and 1100111;
 - S-format for opcode 0100011;
 - B-format for opcode 1100011;
 - J-format for opcode 1101111;
 - U-format for opcodes 0110111 and 0010111, taken as {instr[31:12], 12'b0};
 - 0 for any other opcode.
REQ-024 SHALL assign aluop codes as follows:
 - Loads: LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=14.
 - I-ALU: ADDI=5, SLLI=6, SLTI=7, SLTIU=8, XORI=9, SRLI=10, SRAI=11 (selected by instr[30]), ORI=12, ANDI=13.
 - Stores: SB=15, SH=16, SW=17, SD=28.
 - R-type: ADD=18, SUB=19, SLL=20, SLT=21, SLTU=22, XOR=23, SRL=24, SRA=25, OR=26, AND=27.
 - Branches: BEQ=29, BNE=30, BLT=31, BGE=32, BLTU=33, BGEU=34.
 - Others: JALR=35, LUI=36, AUIPC=37, JAL=38.
REQ-025 SHALL set control strobes per instruction class:
 - R-type: regwrite.
 - I-ALU: regwrite and opa.
 - Load: regwrite, memtoreg and opa.
 - Store: memwrite and opa.
 - Branch: branch.
 - JAL: regwrite and jal.
 - JALR: regwrite, jalr and opa.
 - LUI: regwrite and opa.
 - AUIPC: regwrite, opa and opb.
 - All other strobes for each class: 0.
REQ-026 SHALL treat LD and SD as illegal when XLEN=32.
REQ-027 SHALL treat undefined func3 values as illegal: load func3 6/7, store func3 4-7, and branch func3 2/3.
REQ-028 SHALL increment dec_count by 1 on each acceptance, wrapping modulo 2^CNT_W from all-ones to 0.

Reset
REQ-029 SHALL, while rst=1, immediately clear out_valid, all control strobes, out_illegal, out_aluop, out_imm, the register indices, and dec_count.
REQ-030 SHALL keep in_ready=1 while rst=1.
REQ-031 SHALL discard any instruction held in the output stage when rst asserts mid-operation.

Configuration
REQ-032 SHALL use macro DECODE_ILLEGAL_TRAP_EN to enable illegal-instruction detection.
REQ-033 SHALL, when DECODE_ILLEGAL_TRAP_EN is defined, set out_illegal=1 for an unknown opcode or any illegal case in REQ-026/027, and force all strobes and aluop to 0 for that instruction; it still counts and flows through the output stage.
REQ-034 SHALL, when DECODE_ILLEGAL_TRAP_EN is undefined, tie out_illegal to 0 and decode illegal cases as NOP (all strobes 0, aluop 0).

Verification
REQ-035 SHALL verify back-to-back flow: addi x1,x2,-5 (0xFFB10093) then sub x3,x1,x2 with out_ready=1 -> cycle+1 aluop=5, imm=0xFFFFFFFB, regwrite=1, opa=1; cycle+2 aluop=19, rd=3.
REQ-036 SHALL verify backpressure: out_ready=0 for 3 cycles with a valid held -> in_ready=0 and out_* stable; raise out_ready -> the next instruction appears one cycle later, with no loss or duplication.
REQ-037 SHALL verify flush: flush together with in_valid while out_valid=1 -> out_valid=0 next cycle and dec_count unchanged.
REQ-038 SHALL verify immediates: beq with imm=-4 -> imm=0xFFFFFFFC, aluop=29, branch=1; lui 0x12345 -> imm=0x12345000, aluop=36.
REQ-039 SHALL verify XLEN=32 with ld (func3=3, opcode 0000011): with the macro, out_illegal=1 and regwrite=0; without it, out_illegal=0 and all strobes 0.
REQ-040 SHALL verify counter wrap and reset: CNT_W=4 with 17 accepts -> dec_count=1; asserting rst mid-stream -> out_valid=0 and dec_count=0 without waiting for a clock edge.
